// File: rtl/decode_pkg.sv
// ============================================================================
// decode_pkg : shared types and constants for the decode control pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MUL = 3'b100
  } alu_ctrl_e;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mul_state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       pcsrc;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       no_write;
    logic       mem_to_reg;
    logic       alu_src;
    alu_ctrl_e  alu_ctrl;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_bubble();
    ctrl_t b;
    b      = '0;
    b.cond = COND_AL;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/main_alu_dec.sv
// ============================================================================
// main_alu_dec : combinational instruction -> E-stage control payload (MUL_MULTICYCLE_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module main_alu_dec
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output ctrl_t       ctrl_o
);

  ctrl_t      c;
  logic       illegal;
  logic       is_mul;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;

`ifdef MUL_MULTICYCLE_EN
  logic unused_bits;
  assign unused_bits = ^{instr_i[11:8], instr_i[3:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{instr_i[19:16], instr_i[11:8], instr_i[3:0]};
`endif

  always_comb begin
    c       = '0;
    illegal = 1'b0;
    op      = instr_i[27:26];
    funct   = instr_i[25:20];
    rd      = instr_i[15:12];
    c.cond  = instr_i[31:28];
    is_mul  = (op == OP_DP) && (funct[5:4] == 2'b00) && (instr_i[7:4] == 4'b1001);

    case (op)
      OP_DP: begin
        if (is_mul) begin
`ifdef MUL_MULTICYCLE_EN
          c.reg_write  = 1'b1;
          c.alu_ctrl   = ALU_MUL;
          c.flag_write = {funct[0], 1'b0};
          rd           = instr_i[19:16];
`else
          illegal = 1'b1;
`endif
        end else begin
          c.reg_write = 1'b1;
          c.alu_src   = funct[5];
          case (funct[4:1])
            CMD_ADD: begin c.alu_ctrl = ALU_ADD; c.flag_write = {2{funct[0]}}; end
            CMD_SUB: begin c.alu_ctrl = ALU_SUB; c.flag_write = {2{funct[0]}}; end
            CMD_AND: begin c.alu_ctrl = ALU_AND; c.flag_write = {funct[0], 1'b0}; end
            CMD_ORR: begin c.alu_ctrl = ALU_ORR; c.flag_write = {funct[0], 1'b0}; end
            CMD_CMP: begin
              c.alu_ctrl   = ALU_SUB;
              c.no_write   = 1'b1;
              c.flag_write = 2'b11;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      OP_MEM: begin
        c.alu_src  = 1'b1;
        c.alu_ctrl = ALU_ADD;
        if (funct[0]) begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end else begin
          c.mem_write = 1'b1;
        end
      end
      OP_BR: begin
        c.branch   = 1'b1;
        c.alu_src  = 1'b1;
        c.alu_ctrl = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase

    c.pcsrc = c.branch | (c.reg_write & (rd == 4'hF) & ~c.no_write);

    // Bubbles and undefined encodings carry no side effects into E.
    if (!valid_i || illegal) begin
      c         = '0;
      c.cond    = valid_i ? instr_i[31:28] : COND_AL;
      c.illegal = valid_i & illegal;
    end
  end

  assign ctrl_o = c;

endmodule

`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
// ============================================================================
// decode_ctrl_pipe : D->E control register with optional MUL sequencer (MUL_MULTICYCLE_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        FlushE,
  output logic [3:0]  CondE,
  output logic [1:0]  FlagWriteE,
  output logic        PCSrcEIn,
  output logic        RegWriteEIn,
  output logic        MemWriteEIn,
  output logic        BranchEIn,
  output logic        NoWrite,
  output logic        MemtoRegE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        IllegalE,
  output logic        MulStall
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  mul_stall;

  main_alu_dec u_dec (
    .instr_i (InstrD),
    .valid_i (ValidD),
    .ctrl_o  (ctrl_d)
  );

`ifdef MUL_MULTICYCLE_EN
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_e    state_q;
  logic [CW-1:0] cnt_q;

  assign mul_stall = (state_q == MS_BUSY) && (cnt_q != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_q  <= ctrl_bubble();
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else if (FlushE) begin
      ctrl_q  <= ctrl_bubble();
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else if (mul_stall) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      ctrl_q <= ctrl_d;
      // A single-cycle MUL needs no sequencing, so it never leaves IDLE.
      if ((ctrl_d.alu_ctrl == ALU_MUL) && (MUL_CYCLES > 1)) begin
        state_q <= MS_BUSY;
        cnt_q   <= CW'(MUL_CYCLES - 1);
      end else begin
        state_q <= MS_IDLE;
        cnt_q   <= '0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MUL_CYCLES == 0);
  assign mul_stall  = 1'b0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_q <= ctrl_bubble();
    end else if (FlushE) begin
      ctrl_q <= ctrl_bubble();
    end else begin
      ctrl_q <= ctrl_d;
    end
  end
`endif

  // Architectural side effects stay suppressed until the last MUL cycle.
  assign CondE       = ctrl_q.cond;
  assign FlagWriteE  = mul_stall ? 2'b00 : ctrl_q.flag_write;
  assign PCSrcEIn    = ctrl_q.pcsrc & ~mul_stall;
  assign RegWriteEIn = ctrl_q.reg_write & ~mul_stall;
  assign MemWriteEIn = ctrl_q.mem_write & ~mul_stall;
  assign BranchEIn   = ctrl_q.branch;
  assign NoWrite     = ctrl_q.no_write;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUControlE = ctrl_q.alu_ctrl;
  assign IllegalE    = ctrl_q.illegal;
  assign MulStall    = mul_stall;

endmodule

`default_nettype wire

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Decode-stage control generator and D→E control pipeline register for the pipelined ARM core.
- Produces the condition field, flag-write mask and raw write/branch enables that the execute-stage condition unit consumes and gates.
- Adds a multi-cycle MUL sequencer that holds the E stage and stalls upstream stages.

Parameters:
- MUL_CYCLES, 3, number of execute cycles a MUL occupies (≥1; 1 = single-cycle, no stall)

Ports:
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-low reset (asserted at 0)
- InstrD  in  32  instruction in decode
- ValidD  in  1  InstrD is a real instruction (0 = bubble)
- FlushE  in  1  hazard unit: load a bubble into E next edge
- CondE  out  4  registered Instr[31:28]
- FlagWriteE  out  2  registered flag-write mask {NZ, CV}
- PCSrcEIn, RegWriteEIn, MemWriteEIn, BranchEIn, NoWrite  out  1 each  raw E-stage controls (pre-condition)
- MemtoRegE, ALUSrcE  out  1 each  datapath selects
- ALUControlE  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
- IllegalE  out  1  undefined encoding occupies E
- MulStall  out  1  stall F/D and hold E (combinational from state)

Behaviour:
- Reset: all registered outputs 0, CondE=4'b1110, FSM IDLE, counter 0. MulStall=0.
- Decode (comb, Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12]):
  - Op=00 DP: RegWrite=1, ALUSrc=Funct[5]. Cmd Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite=1, S forced).
  - FlagWrite[1]=S. FlagWrite[0]=S & (ADD|SUB|CMP).
  - Other cmd: illegal.
  - Op=01: LDR (Funct[0]=1): RegWrite, MemtoReg, ALUSrc. STR: MemWrite, ALUSrc. ADD.
  - Op=10: Branch=1, ALUSrc=1, ADD.
  - Op=11: illegal.
  - PCSrc = Branch | (RegWrite & Rd==15 & ~NoWrite).
  - Illegal or ValidD=0: all enables, FlagWrite and PCSrc are 0. IllegalE=ValidD & illegal.
- Pipeline register: captures decode outputs every edge unless MulStall=1 (hold).
  - FlushE=1 loads a bubble: enables, FlagWrite and IllegalE are 0; CondE=1110.
  - FlushE overrides hold and aborts the FSM to IDLE.
- MUL FSM (MUL_EN only): MUL = Op=00, Funct[5:4]=00, Instr[7:4]=1001. S=Instr[20]. ALUControl=100. Rd taken from Instr[19:16].
  - IDLE: a MUL captured into E → BUSY with cnt=MUL_CYCLES-1. If MUL_CYCLES=1, stay IDLE.
  - BUSY: MulStall=1 while cnt≠0. In this state RegWriteEIn, FlagWriteE, PCSrcEIn and MemWriteEIn are forced 0. cnt decrements each edge.
  - cnt==0 → MulStall=0. RegWriteEIn=1 and FlagWriteE[1]=S appear for exactly this one cycle, then IDLE, and the next instruction is captured.
  - Back-to-back MULs: the second re-enters BUSY right after the first completes.
- Reset mid-MUL: immediate return to IDLE and bubble state.

Optional Feature:
- MUL_MULTICYCLE_EN.
- Defined: MUL decode plus the FSM/counter as above.
- Undefined: MUL encodings decode as illegal, MulStall is tied 0, and no counter is synthesized.

Decomposition:
- Package decode_pkg:
  - ALU control enum (ADD/SUB/AND/ORR/MUL).
  - Op field constants.
  - DP cmd constants.
  - cond code AL=4'b1110.
  - A packed struct ctrl_t for the register payload.
  - FSM state enum.
- Sub-module main_alu_dec: combinational InstrD→ctrl_t. The top holds the register and the FSM.

Test Plan:
- Reset low mid-run → all enables 0, CondE=1110, MulStall=0. Release → first capture on the next edge.
- InstrD=0xE0910002 (ADDS) → next cycle RegWriteEIn=1, FlagWriteE=11, ALUControlE=000, CondE=1110. CMP 0xE3510005 → NoWrite=1, FlagWriteE=11, ALUControlE=001.
- LDR PC (0xE591F000) → RegWriteEIn=1, MemtoRegE=1, PCSrcEIn=1. STR 0xE5812004 → MemWriteEIn=1, RegWriteEIn=0. B 0xEA000002 → BranchEIn=1, PCSrcEIn=1.
- MUL 0xE0000291, MUL_CYCLES=3, MUL_MULTICYCLE_EN → MulStall=1 for 2 cycles with RegWriteEIn=0, then 1 cycle with RegWriteEIn=1, MulStall=0. Next instruction captured after that. Macro off → IllegalE=1, no stall.
- FlushE=1 during MUL BUSY → next edge bubble, MulStall=0, FSM IDLE. FlushE together with a valid ADD → bubble, not ADD.
- Op=11 instruction and ValidD=0 → all enables 0. IllegalE=1 only for the valid Op=11 case.
